// File: rtl/correlate_sched.sv
// Stereo census correlator issue scheduler.
// Pairs left/right vectors under output credits and walks the frame.
module correlate_sched #(
  parameter int F_WIDTH     = 320,
  parameter int F_HEIGHT    = 240,
  parameter int BV_LEN      = 72,
  parameter int OUT_CREDITS = 16,
  parameter int PIPE_LAT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BV_LEN-1:0] left_bv,
  input  logic              left_valid,
  output logic              left_ready,
  input  logic [BV_LEN-1:0] right_bv,
  input  logic              right_valid,
  output logic              right_ready,
  output logic [BV_LEN-1:0] corr_left_bitvec,
  output logic [BV_LEN-1:0] corr_right_bitvec,
  output logic              corr_bitvec_val,
  output logic [9:0]        corr_x,
  output logic [9:0]        corr_y,
  input  logic              disp_pop,
  output logic              busy,
  output logic              frame_done,
  output logic              credit_err
);

  localparam int CW = $clog2(OUT_CREDITS + 1);
  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [DW-1:0] drain;
  logic [CW-1:0] credits;
  logic          issue;
  logic          last_x;
  logic          last_y;

  assign last_x = (x == 10'(F_WIDTH - 1));
  assign last_y = (y == 10'(F_HEIGHT - 1));

  // Reset and abort both mask the combinational strobes in their cycle.
  always_comb begin
    issue = 1'b0;
    frame_done = 1'b0;
    if (!reset && !abort) begin
      issue = (state == RUN) && left_valid && right_valid
              && (credits != '0);
      frame_done = (state == DRAIN) && (drain == '0);
    end
  end

  assign left_ready  = issue;
  assign right_ready = issue;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      drain             <= '0;
      credits           <= CW'(OUT_CREDITS);
      credit_err        <= 1'b0;
      corr_bitvec_val   <= 1'b0;
      corr_left_bitvec  <= '0;
      corr_right_bitvec <= '0;
      corr_x            <= '0;
      corr_y            <= '0;
    end else begin
      corr_bitvec_val <= issue;
      if (issue) begin
        corr_left_bitvec  <= left_bv;
        corr_right_bitvec <= right_bv;
        corr_x            <= x;
        corr_y            <= y;
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= RUN;
            x     <= '0;
            y     <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            drain <= '0;
          end else if (issue) begin
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                state <= DRAIN;
                drain <= DW'(PIPE_LAT);
                y     <= '0;
              end else begin
                y <= y + 10'd1;
              end
            end else begin
              x <= x + 10'd1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            drain <= '0;
          end else if (drain == '0) begin
            state <= IDLE;
          end else begin
            drain <= drain - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Credits track free downstream slots; overflow saturates and latches.
      if (issue && !disp_pop) begin
        credits <= credits - CW'(1);
      end else if (!issue && disp_pop) begin
        if (credits == CW'(OUT_CREDITS)) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CW'(1);
        end
      end
    end
  end

endmodule
